// File: rtl/fm_demod_ctrl_if.sv
// Handshake/bus bundle for the FM demod front end: sample input stream,
// qarctan start/ready/done port and demodulated output stream.
`timescale 1ns/1ps
interface fm_demod_ctrl_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_i;
  logic signed [31:0] in_q;
  logic               arctan_start;
  logic               arctan_ready;
  logic signed [31:0] arctan_x;
  logic signed [31:0] arctan_y;
  logic signed [31:0] arctan_angle;
  logic               arctan_done;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;

  // slave: the demod controller itself
  modport slave (
    input  in_valid, in_i, in_q, arctan_ready, arctan_angle, arctan_done, out_ready,
    output in_ready, arctan_start, arctan_x, arctan_y, out_valid, out_data
  );

  // master: sample source, qarctan and downstream sink seen as one peer
  modport master (
    output in_valid, in_i, in_q, arctan_ready, arctan_angle, arctan_done, out_ready,
    input  in_ready, arctan_start, arctan_x, arctan_y, out_valid, out_data
  );
endinterface

// File: rtl/fm_demod_ctrl.sv
// FM demod front end: conjugate product of consecutive Q10 I/Q samples,
// hand-off to qarctan, gain scaling of the returned angle.
`timescale 1ns/1ps
module fm_demod_ctrl #(
  parameter int BITS = 10,
  parameter int GAIN = 758
) (
  input  logic                 clk,
  input  logic                 reset,
  fm_demod_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MULT   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  localparam logic signed [63:0] GAIN64 = 64'(GAIN);

  state_t             state_q;
  logic signed [31:0] prev_i_q, prev_q_q;
  logic signed [31:0] cur_i_q,  cur_q_q;
  logic signed [31:0] x_q, y_q;
  logic signed [31:0] out_data_q;
  logic               out_valid_q;

  logic signed [31:0] x_d, y_d, out_data_d;
  logic signed [63:0] pi_e, pq_e, ci_e, cq_e, ang_e;
  logic signed [63:0] xs, ys, gs;

  // Conjugate product and angle scaling; full 64-bit products, floor shift, low word kept
  always_comb begin
    pi_e       = {{32{prev_i_q[31]}}, prev_i_q};
    pq_e       = {{32{prev_q_q[31]}}, prev_q_q};
    ci_e       = {{32{cur_i_q[31]}},  cur_i_q};
    cq_e       = {{32{cur_q_q[31]}},  cur_q_q};
    ang_e      = {{32{bus.arctan_angle[31]}}, bus.arctan_angle};
    xs         = (pi_e * ci_e + pq_e * cq_e) >>> BITS;
    ys         = (pi_e * cq_e - pq_e * ci_e) >>> BITS;
    gs         = (GAIN64 * ang_e) >>> BITS;
    x_d        = xs[31:0];
    y_d        = ys[31:0];
    out_data_d = gs[31:0];
  end

  // Control FSM with registered datapath outputs; x/y stay put until the next MULT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prev_i_q    <= '0;
      prev_q_q    <= '0;
      cur_i_q     <= '0;
      cur_q_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          cur_i_q <= bus.in_i;
          cur_q_q <= bus.in_q;
          state_q <= S_MULT;
        end
        S_MULT: begin
          x_q      <= x_d;
          y_q      <= y_d;
          prev_i_q <= cur_i_q;
          prev_q_q <= cur_q_q;
          state_q  <= S_ISSUE;
        end
        S_ISSUE: if (bus.arctan_ready) state_q <= S_WAIT;
        S_WAIT: if (bus.arctan_done) begin
          out_data_q  <= out_data_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUTPUT;
        end
        S_OUTPUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.arctan_start = (state_q == S_ISSUE) && bus.arctan_ready;
  assign bus.arctan_x     = x_q;
  assign bus.arctan_y     = y_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;

endmodule

// File: tb/tb_fm_demod_ctrl.sv
// Bench for fm_demod_ctrl: plays sample source, qarctan and sink; scoreboard
// queues hold expected x/y and output values pushed when a sample is driven.
`timescale 1ns/1ps
module tb_fm_demod_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fm_demod_ctrl_if bus();
  fm_demod_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [63:0]        exp_xy[$];
  logic signed [31:0] exp_out[$];
  logic signed [31:0] m_pi = 0, m_pq = 0;

  function automatic logic signed [63:0] sx(input logic signed [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Model: push expectations for sample (si,sq) with qarctan answering ang
  task automatic push_model(input logic signed [31:0] si, sq, ang);
    logic signed [63:0] px, py, po;
    px = (sx(m_pi) * sx(si) + sx(m_pq) * sx(sq)) >>> 10;
    py = (sx(m_pi) * sx(sq) - sx(m_pq) * sx(si)) >>> 10;
    po = (64'sd758 * sx(ang)) >>> 10;
    exp_xy.push_back({px[31:0], py[31:0]});
    exp_out.push_back(po[31:0]);
    m_pi = si;
    m_pq = sq;
  endtask

  // One full transaction; hold_next keeps in_valid high with (ni,nq) during output stall
  task automatic do_sample(input logic signed [31:0] si, sq, ang,
                           input int rdy_dly, arc_lat, out_dly,
                           input bit hold_next, input logic signed [31:0] ni, nq);
    logic [63:0] xy;
    logic signed [31:0] ex, ey, eo;
    int t;
    push_model(si, sq, ang);
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_timeout got=%b want=1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_i = si; bus.in_q = sq;
    bus.arctan_ready = (rdy_dly == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL accept_in_ready got=%b want=0", bus.in_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < rdy_dly; k++) begin
      bus.arctan_done = (k == 2); bus.arctan_angle = 32'sd12345;
      #1;
      n_vec++;
      if (bus.arctan_start !== 1'b0) begin n_err++; $display("FAIL stall_start k=%0d got=%b want=0", k, bus.arctan_start); end
      @(posedge clk); #1;
      bus.arctan_done = 1'b0;
    end
    bus.arctan_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.arctan_start !== 1'b1) begin n_err++; $display("FAIL issue_start got=%b want=1", bus.arctan_start); end
    xy = exp_xy.pop_front();
    ex = xy[63:32]; ey = xy[31:0];
    n_vec++;
    if (bus.arctan_x !== ex || bus.arctan_y !== ey)
      begin n_err++; $display("FAIL issue_xy got=%0d,%0d want=%0d,%0d", bus.arctan_x, bus.arctan_y, ex, ey); end
    @(posedge clk); #1;
    n_vec++;
    if (bus.arctan_start !== 1'b0) begin n_err++; $display("FAIL wait_start got=%b want=0", bus.arctan_start); end
    bus.arctan_ready = 1'b0;
    for (int k = 0; k < arc_lat; k++) begin
      n_vec++;
      if (bus.arctan_x !== ex || bus.arctan_y !== ey || bus.out_valid !== 1'b0)
        begin n_err++; $display("FAIL wait_hold got=%0d,%0d,%b want=%0d,%0d,0", bus.arctan_x, bus.arctan_y, bus.out_valid, ex, ey); end
      @(posedge clk); #1;
    end
    bus.arctan_done = 1'b1; bus.arctan_angle = ang;
    @(posedge clk); #1;
    bus.arctan_done = 1'b0; bus.arctan_angle = 32'sd777;
    eo = exp_out.pop_front();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== eo)
      begin n_err++; $display("FAIL out got=%b,%0d want=1,%0d", bus.out_valid, bus.out_data, eo); end
    if (hold_next) begin bus.in_valid = 1'b1; bus.in_i = ni; bus.in_q = nq; end
    for (int k = 0; k < out_dly; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== eo || bus.in_ready !== 1'b0 || bus.arctan_x !== ex)
        begin n_err++; $display("FAIL out_hold k=%0d got=%b,%0d,%b want=1,%0d,0", k, bus.out_valid, bus.out_data, bus.in_ready, eo); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_err++; $display("FAIL handoff got=%b,%b want=0,1", bus.out_valid, bus.in_ready); end
    if (hold_next) begin
      // in_valid still high: accepted on the very next edge, not before
      @(posedge clk); #1;
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL held_accept got=%b want=0", bus.in_ready); end
      // finish that transaction with a plain zero-angle answer
      push_model(ni, nq, 32'sd0);
      bus.in_valid = 1'b0;
      bus.arctan_ready = 1'b1;
      @(posedge clk); #1;
      xy = exp_xy.pop_front();
      n_vec++;
      if (bus.arctan_start !== 1'b1 || bus.arctan_x !== xy[63:32] || bus.arctan_y !== xy[31:0])
        begin n_err++; $display("FAIL held_issue got=%b,%0d,%0d want=1,%0d,%0d", bus.arctan_start, bus.arctan_x, bus.arctan_y, $signed(xy[63:32]), $signed(xy[31:0])); end
      @(posedge clk); #1;
      bus.arctan_ready = 1'b0; bus.arctan_done = 1'b1; bus.arctan_angle = 32'sd0;
      @(posedge clk); #1;
      bus.arctan_done = 1'b0;
      eo = exp_out.pop_front();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== eo)
        begin n_err++; $display("FAIL held_out got=%b,%0d want=1,%0d", bus.out_valid, bus.out_data, eo); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.arctan_start !== 1'b0 ||
        bus.arctan_x !== 0 || bus.arctan_y !== 0 || bus.out_data !== 0)
      begin n_err++; $display("FAIL reset_state got=%b,%b,%b,%0d,%0d,%0d want=1,0,0,0,0,0",
        bus.in_ready, bus.out_valid, bus.arctan_start, bus.arctan_x, bus.arctan_y, bus.out_data); end
  endtask

  task automatic test_first_sample;
    do_sample(32'sd1024, 32'sd0, 32'sd0, 0, 2, 0, 1'b0, 0, 0);
  endtask

  task automatic test_quadrature;
    do_sample(32'sd0, 32'sd1024, 32'sd1608, 0, 3, 0, 1'b0, 0, 0);
    n_vec++;
    if (bus.out_data !== 32'sd1190) begin n_err++; $display("FAIL quad_const got=%0d want=1190", bus.out_data); end
  endtask

  task automatic test_negative_angle;
    do_sample(-32'sd1024, 32'sd0, -32'sd1608, 0, 1, 0, 1'b0, 0, 0);
    n_vec++;
    if (bus.out_data !== -32'sd1191) begin n_err++; $display("FAIL neg_const got=%0d want=-1191", bus.out_data); end
  endtask

  task automatic test_arctan_stall;
    do_sample(32'sd300, -32'sd500, 32'sd200, 8, 4, 0, 1'b0, 0, 0);
  endtask

  task automatic test_out_backpressure;
    do_sample(32'sd700, 32'sd900, -32'sd3000, 0, 2, 10, 1'b1, -32'sd250, 32'sd640);
  endtask

  task automatic test_overflow;
    do_sample(32'sh7fff_ffff, 32'sh4000_0000, 32'sh7fff_ffff, 0, 1, 0, 1'b0, 0, 0);
    do_sample(32'sh7fff_ffff, -32'sh7fff_ffff, -32'sh7000_0000, 0, 1, 0, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++)
      do_sample($signed($urandom_range(0, 8191)) - 32'sd4096, $signed($urandom_range(0, 8191)) - 32'sd4096,
                $signed($urandom_range(0, 6433)) - 32'sd3216, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_wait;
    int t;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    bus.in_valid = 1'b1; bus.in_i = 32'sd2000; bus.in_q = 32'sd1500; bus.arctan_ready = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.arctan_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.arctan_x !== 0 || bus.arctan_y !== 0 || bus.arctan_start !== 1'b0)
      begin n_err++; $display("FAIL reset_mid_wait got=%b,%b,%0d,%0d want=0,1,0,0", bus.out_valid, bus.in_ready, bus.arctan_x, bus.arctan_y); end
    @(posedge clk); #1;
    reset = 1'b0;
    m_pi = 0; m_pq = 0;
    exp_xy.delete(); exp_out.delete();
    // prev cleared by reset: next sample must issue x=y=0 again
    do_sample(32'sd1024, 32'sd0, 32'sd50, 0, 1, 0, 1'b0, 0, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_i = 0; bus.in_q = 0;
    bus.arctan_ready = 1'b0; bus.arctan_angle = 0; bus.arctan_done = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_first_sample();
    test_quadrature();
    test_negative_angle();
    test_arctan_stall();
    test_out_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
